// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator keypad/operand path:
//   - key-code constants (digit range and the command keys)
//   - entry FSM state encoding (EMPTY / ENTERING / FULL, 2-bit)
//   - BCD digit type
//   - is_digit() helper for key-code classification
// No ports (package).
// -----------------------------------------------------------------------------
package calc_pkg;

   localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
   localparam logic [4:0] CODE_SIGN     = 5'd10;
   localparam logic [4:0] CODE_BACK     = 5'd11;
   localparam logic [4:0] CODE_CLEAR    = 5'd12;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      ENTERING = 2'd1,
      FULL     = 2'd2
   } entry_state_e;

   function automatic logic is_digit(input logic [4:0] code);
      return (code <= KEY_DIGIT_MAX);
   endfunction

endpackage

// File: rtl/key_edge_sync.sv
// -----------------------------------------------------------------------------
// key_edge_sync
// Two-flop synchroniser for the raw keypad key_valid level, followed by a
// rising-edge detector, so a held key yields exactly one event per press.
// Ports:
//   Clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset (all flops clear to 0)
//   level_async  in   unsynchronised key level from the keypad
//   pulse        out  one-cycle strobe, 2 cycles after the level rises
// -----------------------------------------------------------------------------
module key_edge_sync (
   input  logic Clock,
   input  logic reset,
   input  logic level_async,
   output logic pulse
);

   logic sync_p0;
   logic sync_p1;
   logic sync_p2;

   // synchroniser stages, then one delayed copy for the edge compare
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= level_async;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/operand_digit_entry.sv
// -----------------------------------------------------------------------------
// operand_digit_entry
// Keypad-side entry buffer. Turns one-cycle key events into a 3-digit BCD
// value plus sign, held stable for the downstream operand register.
// Handles digit shift-in, backspace, sign toggle, clear-entry and overflow.
//
// Build option: define OPERAND_KEY_EDGE_EN to treat key_valid as a raw
// keypad level (synchronised + rising-edge detected, +2 cycles latency).
// Without it, key_valid is a synchronous one-cycle strobe.
//
// Ports:
//   Clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   entry_enable  in   key events accepted only while high
//   entry_clear   in   clear entry for next operand (ignores entry_enable,
//                      overrides a simultaneous key)
//   key_valid     in   key_code valid strobe (or raw level, see above)
//   key_code      in   0-9 digit, KEY_SIGN / KEY_BACK / KEY_CLEAR commands
//   digit1..3     out  BCD ones / tens / hundreds
//   isNegative    out  sign, 1 = negative
//   digit_count   out  digits entered, 0..3
//   overflow      out  one-cycle pulse: digit rejected, buffer full
// -----------------------------------------------------------------------------
module operand_digit_entry
   import calc_pkg::*;
#(
   parameter logic [4:0] KEY_SIGN      = CODE_SIGN,
   parameter logic [4:0] KEY_BACK      = CODE_BACK,
   parameter logic [4:0] KEY_CLEAR     = CODE_CLEAR,
   parameter bit         ZERO_SUPPRESS = 1'b1
) (
   input  logic       Clock,
   input  logic       reset,
   input  logic       entry_enable,
   input  logic       entry_clear,
   input  logic       key_valid,
   input  logic [4:0] key_code,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic       isNegative,
   output logic [1:0] digit_count,
   output logic       overflow
);

   localparam logic [1:0] ST_EMPTY    = EMPTY;
   localparam logic [1:0] ST_ENTERING = ENTERING;
   localparam logic [1:0] ST_FULL     = FULL;

   logic       key_strobe;
   logic       vld_p0;
   logic       state_illegal;

   logic [1:0] state_p1, state_n;
   logic [1:0] cnt_p1,   cnt_n;
   bcd_t       d1_p1, d1_n;
   bcd_t       d2_p1, d2_n;
   bcd_t       d3_p1, d3_n;
   logic       neg_p1, neg_n;
   logic       ovf_p1, ovf_n;

`ifdef OPERAND_KEY_EDGE_EN
   key_edge_sync u_key_edge_sync (
      .Clock       (Clock),
      .reset       (reset),
      .level_async (key_valid),
      .pulse       (key_strobe)
   );
`else
   assign key_strobe = key_valid;
`endif

   // input stage: accepted key event
   assign vld_p0        = key_strobe & entry_enable;
   assign state_illegal = (state_p1 != ST_EMPTY) && (state_p1 != ST_ENTERING) &&
                          (state_p1 != ST_FULL);

   always_comb begin
      state_n = state_p1;
      cnt_n   = cnt_p1;
      d1_n    = d1_p1;
      d2_n    = d2_p1;
      d3_n    = d3_p1;
      neg_n   = neg_p1;
      ovf_n   = 1'b0;

      // entry_clear outranks any key; a corrupted state encoding also lands
      // here so the buffer recovers to a clean EMPTY entry.
      if (entry_clear || state_illegal) begin
         state_n = ST_EMPTY;
         cnt_n   = 2'd0;
         d1_n    = '0;
         d2_n    = '0;
         d3_n    = '0;
         neg_n   = 1'b0;
      end else if (vld_p0) begin
         if (is_digit(key_code)) begin
            case (state_p1)
               ST_EMPTY: begin
                  // a leading zero carries no value, so it is not counted
                  if (!(ZERO_SUPPRESS && (key_code == 5'd0))) begin
                     d1_n    = key_code[3:0];
                     cnt_n   = 2'd1;
                     state_n = ST_ENTERING;
                  end
               end
               ST_ENTERING: begin
                  d3_n  = d2_p1;
                  d2_n  = d1_p1;
                  d1_n  = key_code[3:0];
                  cnt_n = cnt_p1 + 2'd1;
                  if (cnt_p1 == 2'd2) begin
                     state_n = ST_FULL;
                  end
               end
               default: begin
                  ovf_n = 1'b1;
               end
            endcase
         end else if (key_code == KEY_BACK) begin
            if (state_p1 != ST_EMPTY) begin
               d1_n    = d2_p1;
               d2_n    = d3_p1;
               d3_n    = '0;
               cnt_n   = cnt_p1 - 2'd1;
               state_n = (cnt_p1 == 2'd1) ? ST_EMPTY : ST_ENTERING;
            end
         end else if (key_code == KEY_SIGN) begin
            neg_n = ~neg_p1;
         end else if (key_code == KEY_CLEAR) begin
            state_n = ST_EMPTY;
            cnt_n   = 2'd0;
            d1_n    = '0;
            d2_n    = '0;
            d3_n    = '0;
            neg_n   = 1'b0;
         end
      end
   end

   // registered entry state and outputs
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_p1 <= ST_EMPTY;
         cnt_p1   <= 2'd0;
         d1_p1    <= '0;
         d2_p1    <= '0;
         d3_p1    <= '0;
         neg_p1   <= 1'b0;
         ovf_p1   <= 1'b0;
      end else begin
         state_p1 <= state_n;
         cnt_p1   <= cnt_n;
         d1_p1    <= d1_n;
         d2_p1    <= d2_n;
         d3_p1    <= d3_n;
         neg_p1   <= neg_n;
         ovf_p1   <= ovf_n;
      end
   end

   assign digit1     = d1_p1;
   assign digit2     = d2_p1;
   assign digit3     = d3_p1;
   assign isNegative = neg_p1;
   assign overflow   = ovf_p1;

   always_comb begin
      digit_count = 2'd0;
      case (state_p1)
         ST_FULL:     digit_count = 2'd3;
         ST_ENTERING: digit_count = cnt_p1;
         default:     digit_count = 2'd0;
      endcase
   end

endmodule
